// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: I2C byte register bank; first write byte sets ptr, then data to cfg_out (RW) / status_in (RO) with auto-increment, reads on tx_req
module i2c_reg_bank #(
  parameter int NUM_REGS = 16,
  parameter int RO_BASE = 8,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              addr_hit,
  input  logic                              rw,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  input  logic                              tx_req,
  input  logic                              stop,
  input  logic [8*(NUM_REGS-RO_BASE)-1:0]   status_in,
  output logic [7:0]                        tx_data,
  output logic [8*RO_BASE-1:0]              cfg_out,
  output logic                              wr_strobe,
  output logic [7:0]                        wr_addr,
  output logic [7:0]                        ptr
);
  typedef enum logic [1:0] {IDLE, PTR, WDATA, RDATA} state_t;
  state_t state, state_n;
  logic data_ok, ptr_ld, wdata, wr_en, rd, rd_bad;
  logic [7:0] rd_byte;
  always_comb begin
    state_n = addr_hit ? (rw ? RDATA : PTR) : stop ? IDLE : (state == PTR && rx_valid) ? WDATA : state;
    data_ok = !addr_hit && !stop;
    ptr_ld = data_ok && rx_valid && state == PTR;
    wdata = data_ok && rx_valid && state == WDATA;
    wr_en = wdata && ptr < 8'(RO_BASE);
    rd = data_ok && tx_req && state == RDATA;
    rd_bad = data_ok && tx_req && state != RDATA;
    rd_byte = 8'hFF;
    for (int i = 0; i < RO_BASE; i++) if (ptr == 8'(i)) rd_byte = cfg_out[8*i +: 8];
    for (int i = 0; i < NUM_REGS - RO_BASE; i++) if (ptr == 8'(RO_BASE + i)) rd_byte = status_in[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cfg_out <= {RO_BASE{RESET_VAL}};
      tx_data <= 8'h00;
      ptr <= 8'h00;
      wr_strobe <= 1'b0;
      wr_addr <= 8'h00;
    end else begin
      state <= state_n;
      wr_strobe <= wr_en;
      if (wr_en) wr_addr <= ptr;
      for (int i = 0; i < RO_BASE; i++) if (wr_en && ptr == 8'(i)) cfg_out[8*i +: 8] <= rx_data;
      if (ptr_ld) ptr <= rx_data;
      else if (wdata || rd) ptr <= ptr + 8'd1;
      if (rd) tx_data <= rd_byte;
      else if (rd_bad) tx_data <= 8'hFF;
    end
  end
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: directed stimulus, per-cycle reference model comparison plus literal spot checks
module tb_i2c_reg_bank;
  localparam int NR = 16;
  localparam int RB = 8;
  logic clk = 0, reset = 1, addr_hit = 0, rw = 0, rx_valid = 0, tx_req = 0, stop = 0;
  logic [7:0] rx_data = 0;
  logic [8*(NR-RB)-1:0] status_in = 64'h0F1E2D3C4B5A69C3;
  logic [7:0] tx_data, wr_addr, ptr;
  logic wr_strobe;
  logic [8*RB-1:0] cfg_out;
  int tests = 0, fails = 0;
  logic [7:0] m_cfg [256];
  logic [7:0] m_tx, m_ptr, m_wa;
  logic [8*RB-1:0] m_pack;
  logic m_stb;
  int m_mode;
  bit primed = 0;
  always #5 clk = ~clk;
  i2c_reg_bank #(.NUM_REGS(NR), .RO_BASE(RB), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .addr_hit(addr_hit), .rw(rw), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_req(tx_req), .stop(stop), .status_in(status_in),
    .tx_data(tx_data), .cfg_out(cfg_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .ptr(ptr));
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [7:0] rd_model(input logic [7:0] a);
    if (a < RB) return m_cfg[a];
    if (a < NR) return status_in[8*(int'(a)-RB) +: 8];
    return 8'hFF;
  endfunction
  // mode: 0 idle, 1 awaiting pointer byte, 2 writing data, 3 reading
  always @(negedge clk) begin
    if (primed) begin
      for (int i = 0; i < RB; i++) m_pack[8*i +: 8] = m_cfg[i];
      chk("tx_data", tx_data, m_tx);
      chk("ptr", ptr, m_ptr);
      chk("wr_strobe", wr_strobe, m_stb);
      chk("wr_addr", wr_addr, m_wa);
      chk("cfg_out", cfg_out, m_pack);
    end
    primed = 1;
    if (reset) begin
      for (int i = 0; i < 256; i++) m_cfg[i] = 8'h00;
      m_tx = 0; m_ptr = 0; m_stb = 0; m_wa = 0; m_mode = 0;
    end else begin
      m_stb = 0;
      if (addr_hit) m_mode = rw ? 3 : 1;
      else if (stop) m_mode = 0;
      else begin
        if (tx_req) begin
          if (m_mode == 3) begin m_tx = rd_model(m_ptr); m_ptr = m_ptr + 8'd1; end
          else m_tx = 8'hFF;
        end
        if (rx_valid && m_mode == 1) begin m_ptr = rx_data; m_mode = 2; end
        else if (rx_valid && m_mode == 2) begin
          if (m_ptr < RB) begin m_cfg[m_ptr] = rx_data; m_stb = 1; m_wa = m_ptr; end
          m_ptr = m_ptr + 8'd1;
        end
      end
    end
  end
  task automatic cyc(input logic ah = 0, input logic r = 0, input logic rv = 0,
                     input logic [7:0] d = 0, input logic tr = 0, input logic sp = 0);
    addr_hit = ah; rw = r; rx_valid = rv; rx_data = d; tx_req = tr; stop = sp;
    @(posedge clk); #1;
    addr_hit = 0; rx_valid = 0; tx_req = 0; stop = 0;
  endtask
  task automatic rx(input logic [7:0] d); cyc(0, 0, 1, d); endtask
  task automatic txr(); cyc(0, 0, 0, 8'h00, 1); endtask
  task automatic stp(); cyc(0, 0, 0, 8'h00, 0, 1); endtask
  initial begin
    cyc(); cyc(); reset = 0;
    chk("rst_cfg", cfg_out, 64'h0);
    chk("rst_tx", tx_data, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_stb", wr_strobe, 0);
    cyc(1, 0); rx(8'h02);
    reset = 1; cyc(); reset = 0;
    rx(8'h55);
    chk("abort_cfg", cfg_out, 64'h0);
    chk("abort_stb", wr_strobe, 0);
    chk("abort_ptr", ptr, 0);
    cyc(1, 0); rx(8'h03); rx(8'h66);
    chk("wr_cfg3", cfg_out[31:24], 8'h66);
    chk("wr_stb", wr_strobe, 1);
    chk("wr_addr", wr_addr, 8'h03);
    chk("wr_ptr", ptr, 8'h04);
    cyc();
    chk("wr_stb_off", wr_strobe, 0);
    cyc(1, 0); rx(8'h06); rx(8'hA1);
    chk("burst_stb1", wr_strobe, 1);
    rx(8'hA2);
    chk("burst_stb2", wr_strobe, 1);
    rx(8'hA3);
    chk("burst_nostb", wr_strobe, 0);
    chk("burst_cfg67", cfg_out[63:48], 16'hA2A1);
    chk("burst_ptr", ptr, 8'h09);
    chk("burst_waddr", wr_addr, 8'h07);
    cyc(1, 0); rx(8'h06); stp(); cyc(1, 1);
    txr(); chk("rd_0", tx_data, 8'hA1);
    cyc();
    txr(); chk("rd_1", tx_data, 8'hA2);
    txr(); chk("rd_2", tx_data, 8'hC3);
    chk("rd_ptr", ptr, 8'h09);
    cyc(1, 0); rx(8'h00); rx(8'h5A); stp();
    cyc(1, 0); rx(8'hFF); stp(); cyc(1, 1);
    txr(); chk("oor_ff", tx_data, 8'hFF);
    txr(); chk("wrap_cfg0", tx_data, 8'h5A);
    chk("wrap_ptr", ptr, 8'h01);
    cyc(1, 0); rx(8'h01);
    cyc(0, 0, 1, 8'h77, 0, 1);
    chk("col_cfg1", cfg_out[15:8], 8'h00);
    chk("col_stb", wr_strobe, 0);
    rx(8'h88);
    chk("idle_rx_cfg1", cfg_out[15:8], 8'h00);
    chk("idle_rx_ptr", ptr, 8'h01);
    txr();
    chk("idle_tx", tx_data, 8'hFF);
    chk("idle_tx_ptr", ptr, 8'h01);
    cyc(1, 0); rx(8'h09);
    cyc(1, 1, 0, 8'h00, 1, 1);
    chk("ah_stop_ptr", ptr, 8'h09);
    txr();
    chk("ah_stop_rd", tx_data, 8'h69);
    chk("ah_stop_ptr2", ptr, 8'h0A);
    rx(8'h12);
    chk("rdata_rx_ptr", ptr, 8'h0A);
    cyc(1, 0); rx(8'hFF); rx(8'h11);
    chk("wptr_wrap", ptr, 8'h00);
    chk("wptr_nostb", wr_strobe, 0);
    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
